uart_rx_loader: RTL

//  Consumes the byte stream from the UART receiver (8-bit data plus done strobe).

---
 rtl/uart_rx_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_loader.sv
// UART byte-stream loader: decodes 'L' (load N little-endian words) and 'R' (run)
// commands, writes assembled words to instruction memory, and flags errors/timeouts.
module uart_rx_loader #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_WORD-1:0] o_mem_wdata,
  output logic               o_load_done,
  output logic               o_run,
  output logic               o_err,
  output logic               o_busy
);

  localparam int                 NB_TMO    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [NB_TMO-1:0]  TMO_LAST  = NB_TMO'(TIMEOUT - 1);
  localparam logic [16:0]        MAX_WORDS = 17'(2 ** NB_ADDR);
  localparam logic [NB_ADDR:0]   LEFT_ONE  = (NB_ADDR + 1)'(1);
  localparam logic [7:0]         CMD_LOAD  = 8'h4C;
  localparam logic [7:0]         CMD_RUN   = 8'h52;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CNT_LO = 2'd1,
    ST_CNT_HI = 2'd2,
    ST_DATA   = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_done_q;
  logic [7:0]           r_cnt_lo, w_cnt_lo_nxt;
  logic [1:0]           r_byte_idx, w_idx_nxt;
  logic [NB_ADDR-1:0]   r_addr, w_addr_nxt;
  logic [NB_ADDR:0]     r_words_left, w_left_nxt;
  logic [NB_WORD-1:0]   r_word, w_word_nxt;
  logic [NB_TMO-1:0]    r_tmo, w_tmo_nxt;
  logic                 r_mem_we, r_load_done, r_run, r_err, r_busy;
  logic [NB_ADDR-1:0]   r_mem_addr;
  logic [NB_WORD-1:0]   r_mem_wdata;

  logic                 w_acc, w_we, w_run, w_err, w_done;
  logic [15:0]          w_count;
  logic [NB_WORD-1:0]   w_word_shift;

  assign w_acc        = i_rx_done & ~r_rx_done_q;
  assign w_count      = {i_rx_data, r_cnt_lo};
  assign w_word_shift = {i_rx_data, r_word[NB_WORD-1:NB_DATA]};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_lo_nxt = r_cnt_lo;
    w_idx_nxt    = r_byte_idx;
    w_addr_nxt   = r_addr;
    w_left_nxt   = r_words_left;
    w_word_nxt   = r_word;
    w_tmo_nxt    = r_tmo;
    w_we         = 1'b0;
    w_run        = 1'b0;
    w_err        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (i_rx_data == CMD_LOAD) w_state_nxt = ST_CNT_LO;
          else if (i_rx_data == CMD_RUN) w_run = 1'b1;
          else w_err = 1'b1;
        end
      end
      ST_CNT_LO: begin
        if (w_acc) begin
          w_cnt_lo_nxt = i_rx_data;
          w_state_nxt  = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (w_acc) begin
          if (w_count == 16'd0) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if ({1'b0, w_count} > MAX_WORDS) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_addr_nxt  = '0;
            w_idx_nxt   = 2'd0;
            w_left_nxt  = w_count[NB_ADDR:0];
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_acc) begin
          w_word_nxt = w_word_shift;
          if (r_byte_idx == 2'd3) begin
            w_we       = 1'b1;
            w_idx_nxt  = 2'd0;
            w_addr_nxt = r_addr + NB_ADDR'(1);
            w_left_nxt = r_words_left - LEFT_ONE;
            if (r_words_left == LEFT_ONE) begin
              w_done      = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_byte_idx + 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // An accepted byte always beats expiry; only a silent expiry cycle aborts the command.
    if ((r_state == ST_IDLE) || w_acc) begin
      w_tmo_nxt = '0;
    end else if (r_tmo == TMO_LAST) begin
      w_tmo_nxt   = '0;
      w_err       = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      w_tmo_nxt = r_tmo + NB_TMO'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_rx_done_q  <= 1'b0;
      r_cnt_lo     <= '0;
      r_byte_idx   <= '0;
      r_addr       <= '0;
      r_words_left <= '0;
      r_word       <= '0;
      r_tmo        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_done  <= 1'b0;
      r_run        <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_done_q  <= i_rx_done;
      r_cnt_lo     <= w_cnt_lo_nxt;
      r_byte_idx   <= w_idx_nxt;
      r_addr       <= w_addr_nxt;
      r_words_left <= w_left_nxt;
      r_word       <= w_word_nxt;
      r_tmo        <= w_tmo_nxt;
      r_mem_we     <= w_we;
      r_load_done  <= w_done;
      r_run        <= w_run;
      r_err        <= w_err;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_we) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= w_word_shift;
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_load_done = r_load_done;
  assign o_run       = r_run;
  assign o_err       = r_err;
  assign o_busy      = r_busy;

endmodule
